// File: rtl/e203_subsys_clkdiv_cfg_pkg.sv
// ---------------------------------------------------------------------------
// e203_subsys_clkdiv_cfg_pkg : shared constants for the clock-divider writer
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package e203_subsys_clkdiv_cfg_pkg;

  localparam int CLKDIV_DIV_W = 6;
  localparam int SETTLE_CNT_W = 4;

  typedef logic [1:0] cfg_state_t;

  localparam cfg_state_t ST_IDLE     = 2'd0;
  localparam cfg_state_t ST_WAIT_BND = 2'd1;
  localparam cfg_state_t ST_SETTLE   = 2'd2;

endpackage

`default_nettype wire

// File: rtl/e203_subsys_clkdiv_shadow.sv
// ---------------------------------------------------------------------------
// e203_subsys_clkdiv_shadow : lockstep mirror of the PLL divider counter/flag
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module e203_subsys_clkdiv_shadow
  import e203_subsys_clkdiv_cfg_pkg::*;
#(
  parameter int DIV_W = CLKDIV_DIV_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] div_i,
  input  logic             divby1_i,
  output logic             sat_o,
  output logic             clken_o
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;
  logic             flag_q;
  logic             flag_d;
  logic             sat;

  assign sat = (cnt_q == div_i);

  // Counter and flag freeze in bypass, exactly like the real divider.
  always_comb begin
    cnt_d  = cnt_q;
    flag_d = flag_q;
    if (!divby1_i) begin
      cnt_d  = sat ? '0 : cnt_q + DIV_W'(1);
      flag_d = flag_q ^ sat;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      flag_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      flag_q <= flag_d;
    end
  end

  assign sat_o   = sat;
  assign clken_o = divby1_i | (~flag_q & sat);

endmodule

`default_nettype wire

// File: rtl/e203_subsys_clkdiv_cfg.sv
// ---------------------------------------------------------------------------
// e203_subsys_clkdiv_cfg : glitch-free divide-setting writer for the PLL divider
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module e203_subsys_clkdiv_cfg
  import e203_subsys_clkdiv_cfg_pkg::*;
#(
  parameter int               DIV_W      = CLKDIV_DIV_W,
  parameter logic [DIV_W-1:0] RST_DIV    = '0,
  parameter logic             RST_DIVBY1 = 1'b1,
  parameter int               SETTLE_N   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_divby1,
  input  logic [DIV_W-1:0] req_div,
  output logic [DIV_W-1:0] div_o,
  output logic             divby1_o,
  output logic             clken_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam logic [SETTLE_CNT_W-1:0] SETTLE_LIM = SETTLE_CNT_W'(SETTLE_N);

  cfg_state_t state_q;
  cfg_state_t state_d;

  logic [DIV_W-1:0]        pend_div_q;
  logic                    pend_byp_q;
  logic [DIV_W-1:0]        div_q;
  logic                    divby1_q;
  logic [SETTLE_CNT_W-1:0] settle_cnt_q;
  logic [SETTLE_CNT_W-1:0] settle_inc;
  logic                    done_q;
  logic                    busy_tail_q;

  logic sat;
  logic clken;
  logic bnd;
  logic hs;
  logic same_cfg;
  logic apply;
  logic settle_fin;

  e203_subsys_clkdiv_shadow #(
    .DIV_W (DIV_W)
  ) u_shadow (
    .clk      (clk),
    .rst_n    (rst_n),
    .div_i    (div_q),
    .divby1_i (divby1_q),
    .sat_o    (sat),
    .clken_o  (clken)
  );

  assign bnd        = divby1_q | sat;
  assign hs         = req_valid & req_ready;
  // The divide value is irrelevant when both old and new settings are bypass.
  assign same_cfg   = (req_divby1 == divby1_q) & (req_divby1 | (req_div == div_q));
  assign apply      = (state_q == ST_WAIT_BND) & bnd;
  assign settle_inc = settle_cnt_q + SETTLE_CNT_W'(1);
  assign settle_fin = (state_q == ST_SETTLE) & clken & (settle_inc == SETTLE_LIM);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (hs && !same_cfg) begin
          state_d = ST_WAIT_BND;
        end
      end
      ST_WAIT_BND: begin
        if (bnd) begin
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (settle_fin) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    busy_o    = 1'b0;
    req_ready = (state_q == ST_IDLE) & rst_n;
    busy_o    = (state_q != ST_IDLE) | busy_tail_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_div_q <= '0;
      pend_byp_q <= 1'b0;
    end else if (hs) begin
      pend_div_q <= req_div;
      pend_byp_q <= req_divby1;
    end
  end

  // New setting lands on the same edge the divider counter wraps to zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_q    <= RST_DIV;
      divby1_q <= RST_DIVBY1;
    end else if (apply) begin
      div_q    <= pend_div_q;
      divby1_q <= pend_byp_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      settle_cnt_q <= '0;
    end else if (apply) begin
      settle_cnt_q <= '0;
    end else if ((state_q == ST_SETTLE) && clken) begin
      settle_cnt_q <= settle_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      done_q      <= 1'b0;
      busy_tail_q <= 1'b0;
    end else begin
      done_q      <= (hs & same_cfg) | settle_fin;
      busy_tail_q <= settle_fin;
    end
  end

  assign div_o    = div_q;
  assign divby1_o = divby1_q;
  assign clken_o  = clken;
  assign done_o   = done_q;

endmodule

`default_nettype wire
